// File: rtl/muldiv_sched.sv
// -----------------------------------------------------------------------------
// muldiv_sched
//   Sequencer for a 32-iteration radix-2 divider sitting in the EX stage.
//   Accepts a divide from EX, drives the divider through 32 quotient-bit
//   iterations, writes HI/LO in a final write-back cycle and stalls the
//   front of the pipeline while the result is outstanding.
//
// Ports
//   cpu_clk     in   sole clock, rising edge
//   reset       in   synchronous, active-high reset
//   ex_div      in   EX-stage instruction is a valid divide
//   id_hilo_use in   ID-stage instruction is Mfhi/Mflo/Mthi/Mtlo
//   flush       in   pipeline flush, cancels a divide in flight
//   div_start   out  one-cycle pulse: divider latches operands and sign mode
//   div_step    out  divider iterates one quotient bit this cycle
//   div_last    out  final iteration this cycle
//   hilo_we     out  one-cycle pulse: HI <- remainder, LO <- quotient
//   stall       out  holds PC, IF/ID and ID/EX
//   busy        out  sequencer is not idle
//   step_cnt    out  current iteration index, 0..31
//
// Configuration
//   DIV_EARLY_RELEASE_EN  when defined, the divide leaves EX as soon as it is
//                         started; only HI/LO consumers and a following
//                         divide are stalled, and a flush no longer aborts
//                         the divide because it has already retired past EX.
// -----------------------------------------------------------------------------
module muldiv_sched (
    input  logic       cpu_clk,
    input  logic       reset,
    input  logic       ex_div,
    input  logic       id_hilo_use,
    input  logic       flush,
    output logic       div_start,
    output logic       div_step,
    output logic       div_last,
    output logic       hilo_we,
    output logic       stall,
    output logic       busy,
    output logic [4:0] step_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t     r_state;
    logic [4:0] r_step_cnt;

    logic w_start;
    logic w_last;
    logic w_abort;
    logic w_run_req;

    assign w_start = (r_state == S_IDLE) && ex_div && !flush;
    assign w_last  = (r_step_cnt == 5'd31);

`ifdef DIV_EARLY_RELEASE_EN
    // The divide has left EX; flush belongs to younger instructions.
    assign w_abort   = 1'b0;
    // Only HI/LO consumers and a following divide must wait for the result.
    assign w_run_req = id_hilo_use | ex_div;
`else
    assign w_abort   = flush;
    // The divide itself sits in EX for the whole run, so RUN always holds.
    assign w_run_req = 1'b1 | id_hilo_use;
`endif

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_step_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_step_cnt <= '0;
                    if (w_start) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_abort) begin
                        r_state    <= S_IDLE;
                        r_step_cnt <= '0;
                    end else if (w_last) begin
                        r_state    <= S_WB;
                        r_step_cnt <= '0;
                    end else begin
                        r_step_cnt <= r_step_cnt + 5'd1;
                    end
                end
                S_WB: begin
                    r_state    <= S_IDLE;
                    r_step_cnt <= '0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_step_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        div_start = 1'b0;
        div_step  = 1'b0;
        div_last  = 1'b0;
        hilo_we   = 1'b0;
        stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                div_start = w_start;
`ifdef DIV_EARLY_RELEASE_EN
                stall     = 1'b0;
`else
                stall     = w_start;
`endif
            end
            S_RUN: begin
                div_step = 1'b1;
                div_last = w_last;
                stall    = w_run_req && !flush;
            end
            S_WB: begin
                hilo_we = 1'b1;
`ifdef DIV_EARLY_RELEASE_EN
                // Hold a trailing divide in EX until IDLE can start it.
                stall   = ex_div && !flush;
`else
                stall   = 1'b0;
`endif
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    assign busy     = (r_state != S_IDLE);
    assign step_cnt = r_step_cnt;

endmodule

// File: tb/tb_muldiv_sched.sv
module tb_muldiv_sched;

  logic       cpu_clk = 1'b0;
  logic       reset, ex_div, id_hilo_use, flush;
  logic       div_start, div_step, div_last, hilo_we, stall, busy;
  logic [4:0] step_cnt;

  muldiv_sched dut (
    .cpu_clk     (cpu_clk),
    .reset       (reset),
    .ex_div      (ex_div),
    .id_hilo_use (id_hilo_use),
    .flush       (flush),
    .div_start   (div_start),
    .div_step    (div_step),
    .div_last    (div_last),
    .hilo_we     (hilo_we),
    .stall       (stall),
    .busy        (busy),
    .step_cnt    (step_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

`ifdef DIV_EARLY_RELEASE_EN
  localparam bit ER = 1'b1;
`else
  localparam bit ER = 1'b0;
`endif

  localparam int unsigned TIMEOUT = 100000;

  typedef struct {
    string       name;
    bit          rst, ex, hu, fl;
    bit          chk;
    logic [10:0] exp;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;
  bit   done   = 1'b0;

  function automatic void add(string nm, bit rst, bit ex, bit hu, bit fl, bit chk,
                              bit st, bit sp, bit la, bit we, bit sl, bit bz,
                              logic [4:0] cnt);
    vec_t v;
    v.name = nm; v.rst = rst; v.ex = ex; v.hu = hu; v.fl = fl; v.chk = chk;
    v.exp  = {st, sp, la, we, sl, bz, cnt};
    vq.push_back(v);
  endfunction

  function automatic void idle0(string nm, bit ex, bit hu, bit fl);
    add(nm, 0, ex, hu, fl, 1, 0, 0, 0, 0, 0, 0, 5'd0);
  endfunction

  initial begin
    #(TIMEOUT);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: stimulus did not complete within %0d time units", TIMEOUT);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    logic [10:0] act;

    add("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0);
    add("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0);
    idle0("reset_state", 0, 0, 0);

    add("a_start", 0, 1, 0, 0, 1, 1, 0, 0, 0, !ER, 0, 5'd0);
    for (int unsigned k = 1; k <= 32; k++)
      add("a_run", 0, 1, 0, 0, 1, 0, 1, k == 32, 0, 1, 1, 5'(k - 1));
    add("a_wb", 0, 1, 0, 0, 1, 0, 0, 0, 1, ER, 1, 5'd0);
    add("b2b_start", 0, 1, 0, 0, 1, 1, 0, 0, 0, !ER, 0, 5'd0);
    for (int unsigned k = 1; k <= 32; k++)
      add("b2b_run", 0, 0, 1, 0, 1, 0, 1, k == 32, 0, 1, 1, 5'(k - 1));
    add("b2b_wb", 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 5'd0);
    idle0("b2b_idle", 0, 0, 0);

    add("f_start", 0, 1, 0, 0, 1, 1, 0, 0, 0, !ER, 0, 5'd0);
    for (int unsigned k = 1; k <= 9; k++)
      add("f_run", 0, 0, 0, 0, 1, 0, 1, 0, 0, !ER, 1, 5'(k - 1));
    add("f_flush", 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 5'd9);
    if (ER) begin
      for (int unsigned k = 11; k <= 32; k++)
        add("f_cont", 0, 0, 0, 0, 1, 0, 1, k == 32, 0, 0, 1, 5'(k - 1));
      add("f_wb", 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 5'd0);
      idle0("f_idle", 0, 0, 0);
    end else begin
      for (int unsigned k = 0; k < 4; k++) idle0("f_aborted", 0, 0, 0);
    end

    add("r_start", 0, 1, 0, 0, 1, 1, 0, 0, 0, !ER, 0, 5'd0);
    for (int unsigned k = 1; k <= 14; k++)
      add("r_run", 0, 0, 0, 0, 1, 0, 1, 0, 0, !ER, 1, 5'(k - 1));
    add("r_rst", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0);
    for (int unsigned k = 0; k < 4; k++) idle0("r_after", 0, 0, 0);

    idle0("idle_flush", 1, 0, 1);
    idle0("idle_after_flush", 0, 0, 0);
    add("w_start", 0, 1, 0, 0, 1, 1, 0, 0, 0, !ER, 0, 5'd0);
    for (int unsigned k = 1; k <= 32; k++)
      add("w_run", 0, 0, 0, 0, 1, 0, 1, k == 32, 0, !ER, 1, 5'(k - 1));
    add("wb_flush", 0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 1, 5'd0);
    idle0("wb_flush_after", 0, 0, 0);

    if (ER) begin
      add("e1_start", 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 5'd0);
      for (int unsigned k = 1; k <= 32; k++)
        add("e1_run", 0, 0, k >= 5, 0, 1, 0, 1, k == 32, 0, k >= 5, 1, 5'(k - 1));
      add("e1_wb", 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1, 5'd0);
      for (int unsigned k = 34; k <= 40; k++) idle0("e1_idle", 0, 1, 0);
      add("e2_start", 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 5'd0);
      for (int unsigned k = 1; k <= 32; k++)
        add("e2_run", 0, k >= 20, 0, 0, 1, 0, 1, k == 32, 0, k >= 20, 1, 5'(k - 1));
      add("e2_wb", 0, 1, 0, 0, 1, 0, 0, 0, 1, 1, 1, 5'd0);
      add("e2_start2", 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 5'd0);
      for (int unsigned k = 1; k <= 32; k++)
        add("e2_run2", 0, 0, 0, 0, 1, 0, 1, k == 32, 0, 0, 1, 5'(k - 1));
      add("e2_wb2", 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 5'd0);
      idle0("e2_idle", 0, 0, 0);
    end

    reset = 1'b1; ex_div = 1'b0; id_hilo_use = 1'b0; flush = 1'b0;

    @(posedge cpu_clk);
    @(negedge cpu_clk);
    act = {div_start, div_step, div_last, hilo_we, stall, busy, step_cnt};
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL reset_direct got {start,step,last,we,stall,busy,cnt}=%b_%0d expected all zero",
               act[10:5], act[4:0]);
    end

    foreach (vq[i]) begin
      @(posedge cpu_clk);
      #1;
      reset       = vq[i].rst;
      ex_div      = vq[i].ex;
      id_hilo_use = vq[i].hu;
      flush       = vq[i].fl;
      @(negedge cpu_clk);
      if (vq[i].chk) begin
        act = {div_start, div_step, div_last, hilo_we, stall, busy, step_cnt};
        checks++;
        if (act !== vq[i].exp) begin
          errors++;
          $display("FAIL %s vec=%0d got {start,step,last,we,stall,busy,cnt}=%b_%0d expected %b_%0d",
                   vq[i].name, i, act[10:5], act[4:0], vq[i].exp[10:5], vq[i].exp[4:0]);
        end
      end
    end

    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_sched.md
MULDIV_SCHED -- requirements
Module: muldiv_sched

Interface
REQ-001 SHALL have port cpu_clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port ex_div  in  1  the EX-stage instruction is a divide (EX_DivSel of a valid instruction).
REQ-004 SHALL have port id_hilo_use  in  1  the ID-stage instruction is Mfhi/Mflo/Mthi/Mtlo.
REQ-005 SHALL have port flush  in  1  pipeline flush; cancels any divide in flight.
REQ-006 SHALL have port div_start  out  1  one-cycle pulse; divider latches operands and sign mode.
REQ-007 SHALL have port div_step  out  1  divider iterates one quotient bit this cycle.
REQ-008 SHALL have port div_last  out  1  final iteration this cycle.
REQ-009 SHALL have port hilo_we  out  1  one-cycle pulse; HI <- remainder, LO <- quotient.
REQ-010 SHALL have port stall  out  1  holds PC, IF/ID and ID/EX contents.
REQ-011 SHALL have port busy  out  1  state is not IDLE.
REQ-012 SHALL have port step_cnt  out  5  current iteration index, 0..31.

Function
REQ-013 SHALL implement the states IDLE, RUN and WB; busy SHALL be 1 in RUN and WB.
REQ-014 IDLE: if ex_div=1 and flush=0, div_start SHALL be 1 in the same cycle (Mealy), next state RUN, step_cnt <- 0; otherwise the block SHALL stay in IDLE.
REQ-015 RUN: div_step SHALL be 1 and step_cnt SHALL increment by 1 each cycle; at step_cnt=31, div_last SHALL be 1 and the next state SHALL be WB.
REQ-016 WB: hilo_we SHALL be 1 for exactly one cycle and the next state SHALL be IDLE; ex_div SHALL NOT trigger div_start while in WB.
REQ-017 Latency: div_start at cycle 0; div_step at cycles 1..32; hilo_we at cycle 33.
REQ-018 Without the early-release feature, stall SHALL be 1 in the IDLE start cycle and in every RUN cycle, and 0 in WB, so the divide leaves EX in the WB cycle; total stall is 33 cycles.
REQ-019 Flush in RUN SHALL force the next state to IDLE with step_cnt <- 0, and no hilo_we SHALL follow; div_step SHALL still be asserted in the flush cycle.
REQ-020 Flush in IDLE SHALL suppress div_start; flush in WB SHALL NOT suppress hilo_we.
REQ-021 When flush is 1, stall SHALL be 0 in every state.
REQ-022 step_cnt SHALL NOT wrap inside RUN; it holds 0 in IDLE and WB.
REQ-023 All outputs SHALL be 0 in IDLE when ex_div=0.

Reset
REQ-024 Reset SHALL take priority over all other inputs, including mid-RUN.
REQ-025 On reset the block SHALL enter IDLE with step_cnt=0.
REQ-026 In the cycle after reset, all outputs SHALL be 0, with no hilo_we for an aborted divide.

Configuration
REQ-027 Macro DIV_EARLY_RELEASE_EN SHALL select early release.
REQ-028 With DIV_EARLY_RELEASE_EN defined, stall SHALL be 0 in the IDLE start cycle.
REQ-029 With DIV_EARLY_RELEASE_EN defined, stall in RUN SHALL equal (id_hilo_use | ex_div).
REQ-030 With DIV_EARLY_RELEASE_EN defined, stall in WB SHALL equal ex_div, so that a trailing divide is held for the next IDLE start.
REQ-031 With DIV_EARLY_RELEASE_EN defined, flush in RUN SHALL NOT abort the divide, because the instruction has already retired past EX.
REQ-032 Without DIV_EARLY_RELEASE_EN, behaviour SHALL be exactly REQ-018 and REQ-019.

Verification
REQ-033 Reset, then ex_div=1 held (macro off) -> div_start at c0; div_step c1..c32; div_last c32 with step_cnt=31; hilo_we c33; stall=1 for c0..c32 and 0 at c33.
REQ-034 Flush at c10 of RUN (macro off) -> state IDLE at c11, step_cnt=0, no hilo_we, stall=0 at c10.
REQ-035 Reset asserted at c15 of RUN -> c16 all outputs 0, busy=0; ex_div=0 afterwards gives no hilo_we.
REQ-036 Back-to-back divides (macro off): second ex_div present at c34 -> div_start at c34, hilo_we at c67.
REQ-037 Macro on, ex_div pulse at c0, id_hilo_use=1 at c5..c40 -> stall=0 at c0..c4, stall=1 at c5..c32, stall=0 at c33 (WB) with hilo_we=1.
REQ-038 Macro on, second divide in EX at c20 -> stall=1 at c20..c33, div_start at c34.
